// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel, runtime-programmable clock divider and tick generator.
//
// Each channel divides clk by its own divisor. A write only updates the channel's
// shadow divisor. The shadow moves into the active divisor at the end of the current
// period, or on any edge while the channel is disabled (divisor 0). A running period
// is therefore never cut short or stretched.
//
// Per channel, clkout, tick and pending are registered. They always reflect the
// current active divisor D, counter C and shadow S:
//   clkout  = (D >= 2) && (C >= D - D/2)  -- low for ceil(D/2) cycles, then high
//   tick    = (D >= 1) && (C == D - 1)    -- last cycle of each period
//   pending = (S != D)
//
// Write port: wr_en is a single-cycle strobe. There is no ready signal, so a write
// is always accepted on the edge where wr_en is 1. Addresses wr_ch >= N_CH are
// silently ignored.
//
// Optional build macro CLK_DIV_MULTI_SYNC_EN adds a `sync` input. On any edge with
// sync=1, every channel loads its shadow divisor and restarts from C=0, which
// phase-aligns all channels. rst still has priority over sync.

module clk_div_multi #(
    parameter int          N_CH        = 4,
    parameter int          CH_W        = 2,
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 100000000
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CLK_DIV_MULTI_SYNC_EN
    input  logic             sync,
`endif
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_div,
    output logic [N_CH-1:0]  clkout,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pending
);

    localparam logic [CNT_W-1:0] ZERO    = '0;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    // Global forced load (phase alignment). It is tied off when sync is not built in.
    logic force_load;
`ifdef CLK_DIV_MULTI_SYNC_EN
    assign force_load = sync;
`else
    assign force_load = 1'b0;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] shadow_q;
        logic [CNT_W-1:0] active_q;
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] shadow_n;
        logic [CNT_W-1:0] active_n;
        logic [CNT_W-1:0] count_n;
        logic             wr_hit;
        logic             period_end;
        logic             load;
        logic             clk_q;
        logic             tick_q;
        logic             pend_q;
        logic             clk_n;
        logic             tick_n;
        logic             pend_n;

        // Next state: a write goes to the shadow only. The active divisor takes the
        // old shadow on a load edge, so a coincident write waits for the next period.
        // Outputs are derived from the next state, so the registered outputs always
        // match the registered D/C/S.
        always_comb begin
            wr_hit     = wr_en && (wr_ch == CH_W'(i));
            period_end = (active_q != ZERO) && (count_q == active_q - ONE);
            load       = period_end || (active_q == ZERO) || force_load;
            shadow_n   = wr_hit ? wr_div : shadow_q;
            active_n   = load ? shadow_q : active_q;
            count_n    = load ? ZERO : count_q + ONE;
            clk_n      = (active_n >= TWO) && (count_n >= active_n - (active_n >> 1));
            tick_n     = (active_n != ZERO) && (count_n == active_n - ONE);
            pend_n     = (shadow_n != active_n);
        end

        // Channel state and registered outputs. Async reset restarts the period at C=0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_q <= DEF_DIV;
                active_q <= DEF_DIV;
                count_q  <= ZERO;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
                pend_q   <= 1'b0;
            end else begin
                shadow_q <= shadow_n;
                active_q <= active_n;
                count_q  <= count_n;
                clk_q    <= clk_n;
                tick_q   <= tick_n;
                pend_q   <= pend_n;
            end
        end

        assign clkout[i]  = clk_q;
        assign tick[i]    = tick_q;
        assign pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: self-checking bench for clk_div_multi.
// Configuration: N_CH=3, CH_W=2, CNT_W=16, DEFAULT_DIV=4. Channel code 3 is an
// illegal address in this configuration.
// Timing: inputs are driven and outputs are sampled on the falling edge of clk.
// t=0 is the falling edge at which rst is released.
// Optional build macro CLK_DIV_MULTI_SYNC_EN enables the sync test.

module tb_clk_div_multi;
    localparam int N_CH        = 3;
    localparam int CH_W        = 2;
    localparam int CNT_W       = 16;
    localparam int DEFAULT_DIV = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [CH_W-1:0]  wr_ch = '0;
    logic [CNT_W-1:0] wr_div = '0;
    logic [N_CH-1:0]  clkout;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  pending;
`ifdef CLK_DIV_MULTI_SYNC_EN
    logic             sync = 1'b0;
`endif

    logic [8:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    clk_div_multi #(
        .N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef CLK_DIV_MULTI_SYNC_EN
        .sync(sync),
`endif
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_div(wr_div),
        .clkout(clkout),
        .tick(tick),
        .pending(pending)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Expected {clkout, tick} for a channel at counter c with divisor d.
    function automatic logic [1:0] wave(input int c, input int d);
        logic [1:0] w;
        w[1] = (d >= 2) && (c >= d - d / 2);
        w[0] = (d >= 1) && (c == d - 1);
        return w;
    endfunction

    // Pack the expected per-channel state into the {clkout, tick, pending} vector.
    function automatic logic [8:0] pack3(input int c0, input int d0, input logic p0,
                                         input int c1, input int d1, input logic p1,
                                         input int c2, input int d2, input logic p2);
        logic [1:0] w0;
        logic [1:0] w1;
        logic [1:0] w2;
        w0 = wave(c0, d0);
        w1 = wave(c1, d1);
        w2 = wave(c2, d2);
        return {w2[1], w1[1], w0[1], w2[0], w1[0], w0[0], p2, p1, p0};
    endfunction

    // Reset driver: hold rst for 3 cycles and release it on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
`ifdef CLK_DIV_MULTI_SYNC_EN
        sync  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        logic [8:0] want;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({clkout, tick, pending} !== 9'd0) begin
            errors++;
            $display("FAIL reset_hold got=%b want=%b", {clkout, tick, pending}, 9'd0);
        end
        rst = 1'b0;
        for (int t = 0; t < 12; t++)
            exp_q.push_back(pack3(t % 4, 4, 1'b0, t % 4, 4, 1'b0, t % 4, 4, 1'b0));
        for (int t = 0; t < 12; t++) begin
            got  = {clkout, tick, pending};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_pattern t=%0d got=%b want=%b", t, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_odd_divisor();
        logic [8:0] got;
        logic [8:0] want;
        do_reset();
        for (int t = 0; t <= 18; t++) begin
            if (t < 4) exp_q.push_back(pack3(t, 4, 1'b0, t, 4, t >= 1, t, 4, 1'b0));
            else       exp_q.push_back(pack3(t % 4, 4, 1'b0, (t - 4) % 5, 5, 1'b0, t % 4, 4, 1'b0));
        end
        for (int t = 0; t <= 18; t++) begin
            got  = {clkout, tick, pending};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL odd_divisor t=%0d got=%b want=%b", t, got, want);
            end
            wr_en  = (t == 0);
            wr_ch  = 2'd1;
            wr_div = CNT_W'(5);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_glitch_free();
        logic [8:0] got;
        logic [8:0] want;
        do_reset();
        for (int t = 0; t <= 20; t++) begin
            if (t < 4) exp_q.push_back(pack3(t, 4, t >= 1, t, 4, 1'b0, t, 4, 1'b0));
            else       exp_q.push_back(pack3((t - 4) % 8, 8, 1'b0, t % 4, 4, 1'b0, t % 4, 4, 1'b0));
        end
        for (int t = 0; t <= 20; t++) begin
            got  = {clkout, tick, pending};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL glitch_free t=%0d got=%b want=%b", t, got, want);
            end
            wr_en  = (t == 0);
            wr_ch  = 2'd0;
            wr_div = CNT_W'(8);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_write_on_load();
        logic [8:0] got;
        logic [8:0] want;
        do_reset();
        for (int t = 0; t <= 20; t++) begin
            if (t < 4)      exp_q.push_back(pack3(t, 4, 1'b0, t, 4, 1'b0, t, 4, 1'b0));
            else if (t < 8) exp_q.push_back(pack3(t % 4, 4, 1'b0, t % 4, 4, 1'b0, t - 4, 4, 1'b1));
            else            exp_q.push_back(pack3(t % 4, 4, 1'b0, t % 4, 4, 1'b0, (t - 8) % 6, 6, 1'b0));
        end
        for (int t = 0; t <= 20; t++) begin
            got  = {clkout, tick, pending};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL write_on_load t=%0d got=%b want=%b", t, got, want);
            end
            wr_en  = (t == 3);
            wr_ch  = 2'd2;
            wr_div = CNT_W'(6);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_disable_enable();
        logic [8:0] got;
        logic [8:0] want;
        int c0;
        int d0;
        logic p0;
        do_reset();
        for (int t = 0; t <= 30; t++) begin
            if (t < 4)        begin c0 = t;            d0 = 4; p0 = (t >= 1); end
            else if (t <= 11) begin c0 = 0;            d0 = 0; p0 = 1'b0;     end
            else if (t == 12) begin c0 = 0;            d0 = 0; p0 = 1'b1;     end
            else if (t <= 20) begin c0 = (t - 13) % 2; d0 = 2; p0 = 1'b0;     end
            else if (t <= 22) begin c0 = t - 21;       d0 = 2; p0 = 1'b1;     end
            else              begin c0 = 0;            d0 = 1; p0 = 1'b0;     end
            exp_q.push_back(pack3(c0, d0, p0, t % 4, 4, 1'b0, t % 4, 4, 1'b0));
        end
        for (int t = 0; t <= 30; t++) begin
            got  = {clkout, tick, pending};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL disable_enable t=%0d got=%b want=%b", t, got, want);
            end
            wr_en  = (t == 0) || (t == 11) || (t == 20);
            wr_ch  = 2'd0;
            wr_div = (t == 11) ? CNT_W'(2) : ((t == 20) ? CNT_W'(1) : CNT_W'(0));
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [8:0] got;
        logic [8:0] want;
        do_reset();
        for (int t = 0; t <= 15; t++) begin
            if (t < 4) exp_q.push_back(pack3(t, 4, t >= 1, t, 4, t >= 2, t, 4, t >= 3));
            else       exp_q.push_back(pack3((t - 4) % 2, 2, 1'b0, (t - 4) % 3, 3, 1'b0, 0, 0, 1'b0));
        end
        for (int t = 0; t <= 15; t++) begin
            got  = {clkout, tick, pending};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back t=%0d got=%b want=%b", t, got, want);
            end
            wr_en  = (t <= 2);
            wr_ch  = CH_W'(t);
            wr_div = (t == 0) ? CNT_W'(2) : ((t == 1) ? CNT_W'(3) : CNT_W'(0));
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_illegal_and_async_reset();
        logic [8:0] got;
        logic [8:0] want;
        do_reset();
        // Writes to channel 3 (nonexistent) and a rewrite of ch1 with its own divisor.
        for (int t = 0; t < 12; t++)
            exp_q.push_back(pack3(t % 4, 4, 1'b0, t % 4, 4, 1'b0, t % 4, 4, 1'b0));
        for (int t = 0; t < 12; t++) begin
            got  = {clkout, tick, pending};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL illegal_channel t=%0d got=%b want=%b", t, got, want);
            end
            wr_en  = (t == 1) || (t == 5);
            wr_ch  = (t == 1) ? 2'd3 : 2'd1;
            wr_div = (t == 1) ? CNT_W'(7) : CNT_W'(4);
            @(negedge clk);
        end
        wr_en = 1'b0;
        // Now at t=12 (C=0). Advance to C=3, where clkout and tick are both high.
        repeat (3) @(negedge clk);
        checks++;
        if ({clkout, tick} !== 6'b111_111) begin
            errors++;
            $display("FAIL async_precond got=%b want=%b", {clkout, tick}, 6'b111_111);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({clkout, tick, pending} !== 9'd0) begin
            errors++;
            $display("FAIL async_reset got=%b want=%b", {clkout, tick, pending}, 9'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 8; t++)
            exp_q.push_back(pack3(t % 4, 4, 1'b0, t % 4, 4, 1'b0, t % 4, 4, 1'b0));
        for (int t = 0; t < 8; t++) begin
            got  = {clkout, tick, pending};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_resume t=%0d got=%b want=%b", t, got, want);
            end
            @(negedge clk);
        end
    endtask

`ifdef CLK_DIV_MULTI_SYNC_EN
    task automatic test_sync();
        logic [8:0] got;
        logic [8:0] want;
        int c1;
        int c2;
        int d2;
        logic p1;
        logic p2;
        do_reset();
        for (int t = 0; t <= 21; t++) begin
            if (t < 4)       begin c1 = t;           p1 = (t >= 1); end
            else if (t <= 8) begin c1 = t - 4;       p1 = 1'b0;     end
            else             begin c1 = (t - 9) % 6; p1 = 1'b0;     end
            if (t <= 8)       begin c2 = t % 4;        d2 = 4; p2 = 1'b0; end
            else if (t <= 12) begin c2 = t - 9;        d2 = 4; p2 = 1'b1; end
            else              begin c2 = (t - 13) % 2; d2 = 2; p2 = 1'b0; end
            exp_q.push_back(pack3((t <= 8) ? t % 4 : (t - 9) % 4, 4, 1'b0,
                                  c1, (t < 4) ? 4 : 6, p1,
                                  c2, d2, p2));
        end
        for (int t = 0; t <= 21; t++) begin
            got  = {clkout, tick, pending};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sync_align t=%0d got=%b want=%b", t, got, want);
            end
            wr_en  = (t == 0) || (t == 8);
            wr_ch  = (t == 8) ? 2'd2 : 2'd1;
            wr_div = (t == 8) ? CNT_W'(2) : CNT_W'(6);
            sync   = (t == 8);
            @(negedge clk);
        end
        wr_en = 1'b0;
        sync  = 1'b0;
    endtask
`endif

    // Test sequence and final report
    initial begin
        test_reset();
        test_odd_divisor();
        test_glitch_free();
        test_write_on_load();
        test_disable_enable();
        test_back_to_back();
        test_illegal_and_async_reset();
`ifdef CLK_DIV_MULTI_SYNC_EN
        test_sync();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
